// File: rtl/acm_init_seq.sv
`default_nettype none
// ============================================================================
// Module   : acm_init_seq
// Purpose  : ACM initialisation sequencer. Walks the ACM lookup table from
//            ACM_START to ACM_END, samples each entry, and writes every valid
//            entry into the analog configuration memory over a ready/enable
//            handshake. Runs once per START pulse, then pulses DONE.
// Ports    : PCLK, PRESETN   - clock, synchronous active-low reset
//            START           - begin a run (sampled only when idle)
//            TBL_ADDR/DATA/DO- lookup table address, data, entry-valid
//            ACM_ADDR/WDATA  - write address and data to the ACM port
//            ACM_WEN/READY   - write request, held until READY accepts it
//            BUSY, DONE      - run in progress, one-cycle completion pulse
//            WCOUNT          - writes accepted in the current or last run
// Revision : 1.0 - initial release
// ============================================================================
module acm_init_seq #(
  parameter int ACM_START   = 0,
  parameter int ACM_END     = 255,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  input  logic       START,
  output logic [7:0] TBL_ADDR,
  input  logic [7:0] TBL_DATA,
  input  logic       TBL_DO,
  output logic [7:0] ACM_ADDR,
  output logic [7:0] ACM_WDATA,
  output logic       ACM_WEN,
  input  logic       ACM_READY,
  output logic       BUSY,
  output logic       DONE,
  output logic [8:0] WCOUNT
);

  localparam logic [7:0] c_start_addr = 8'(ACM_START);
  localparam logic [7:0] c_end_addr   = 8'(ACM_END);
  localparam logic [3:0] c_wait       = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_WRITE  = 3'd2,
    S_SETTLE = 3'd3,
    S_NEXT   = 3'd4,
    S_FIN    = 3'd5
  } state_e;

  state_e     state_q;
  logic [7:0] addr_q;
  logic [7:0] data_q;
  logic [7:0] acm_addr_q;
  logic       acm_wen_q;
  logic       busy_q;
  logic       done_q;
  logic [8:0] wcount_q;
  logic [3:0] wait_q;

  // All outputs come straight from registers; nothing combinational from
  // ACM_READY or the table inputs reaches a port.
  assign TBL_ADDR  = addr_q;
  assign ACM_ADDR  = acm_addr_q;
  assign ACM_WDATA = data_q;
  assign ACM_WEN   = acm_wen_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign WCOUNT    = wcount_q;

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      state_q    <= S_IDLE;
      addr_q     <= 8'd0;
      data_q     <= 8'd0;
      acm_addr_q <= 8'd0;
      acm_wen_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wcount_q   <= 9'd0;
      wait_q     <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            wcount_q <= 9'd0;
            // An empty range finishes at once without touching the table.
            if (c_start_addr > c_end_addr) begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              addr_q  <= c_start_addr;
              busy_q  <= 1'b1;
              state_q <= S_LOOKUP;
            end
          end
        end

        S_LOOKUP: begin
          // Data is captured only for valid entries so an undriven table
          // word behind a skipped entry never reaches ACM_WDATA.
          if (TBL_DO) begin
            data_q     <= TBL_DATA;
            acm_addr_q <= addr_q;
            acm_wen_q  <= 1'b1;
            state_q    <= S_WRITE;
          end else begin
            state_q    <= S_NEXT;
          end
        end

        S_WRITE: begin
          if (ACM_READY) begin
            acm_wen_q <= 1'b0;
            wcount_q  <= wcount_q + 9'd1;
            if (c_wait == 4'd0) begin
              state_q <= S_NEXT;
            end else begin
              wait_q  <= c_wait - 4'd1;
              state_q <= S_SETTLE;
            end
          end
        end

        S_SETTLE: begin
          if (wait_q == 4'd0) begin
            state_q <= S_NEXT;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end

        S_NEXT: begin
          // Compare before incrementing so an end address of 255 never
          // wraps the table address back to 0.
          if (addr_q == c_end_addr) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else begin
            addr_q  <= addr_q + 8'd1;
            state_q <= S_LOOKUP;
          end
        end

        S_FIN: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
